frequency_readout: RTL and testbench

FREQUENCY_READOUT -- requirements
Module: frequency_readout

---
 rtl/frequency_pkg.sv | 31 +++
 rtl/freq_seq_divider.sv | 73 +++++++
 rtl/frequency_readout.sv | 129 ++++++++++++
 tb/tb_frequency_readout.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/frequency_pkg.sv
// Shared constant derivation for the pixel frequency encoder/decoder pair,
// so both sides agree on half-period range, code step and counter width.
package frequency_pkg;

   typedef enum logic [1:0] {
      ST_ARM,
      ST_MEASURE,
      ST_DIVIDE
   } state_t;

   function automatic int calc_max_half(input int clock_freq, input int low_freq);
      return clock_freq / (2 * low_freq);
   endfunction

   function automatic int calc_min_half(input int clock_freq, input int high_freq);
      int h;
      h = clock_freq / (2 * high_freq);
      return (h < 1) ? 1 : h;
   endfunction

   function automatic int calc_step(input int max_half, input int min_half, input int output_bits);
      int s;
      s = (max_half - min_half) / ((1 << output_bits) - 1);
      return (s < 1) ? 1 : s;
   endfunction

   function automatic int calc_cnt_w(input int max_half);
      return $clog2(2 * max_half + 1);
   endfunction

endpackage

// File: rtl/freq_seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle, WIDTH cycles.
// The first bit is resolved in the cycle that accepts start.
module freq_seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic             done
);

   localparam int LW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [LW-1:0]    left;
   logic             running;

   logic [WIDTH-1:0] src_rem;
   logic [WIDTH-1:0] src_quo;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] nxt_rem;
   logic [WIDTH-1:0] nxt_quo;

   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      src_rem = start ? '0 : rem;
      src_quo = start ? dividend : quo;
      shifted = {src_rem, src_quo[WIDTH-1]};
      nxt_rem = shifted[WIDTH-1:0];
      nxt_quo = {src_quo[WIDTH-2:0], 1'b0};
      if (shifted >= {1'b0, divisor}) begin
         nxt_rem = WIDTH'(shifted - {1'b0, divisor});
         nxt_quo = {src_quo[WIDTH-2:0], 1'b1};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem     <= '0;
         quo     <= '0;
         left    <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            running <= 1'b0;
         end else if (start) begin
            rem     <= nxt_rem;
            quo     <= nxt_quo;
            left    <= LW'(WIDTH - 1);
            running <= 1'b1;
         end else if (running) begin
            rem  <= nxt_rem;
            quo  <= nxt_quo;
            left <= left - 1'b1;
            if (left == LW'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo;

endmodule

// File: rtl/frequency_readout.sv
// Recovers the light code from the pixel square wave: measures the half period
// between synchronized edges and maps it onto a code by a sequential divide.
module frequency_readout
   import frequency_pkg::*;
#(
   parameter int CLOCK_FREQ  = 50_000_000,
   parameter int LOW_FREQ    = 1_000,
   parameter int HIGH_FREQ   = 20_000_000,
   parameter int OUTPUT_BITS = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   ENABLE,
   input  logic                   FREQ_IN,
   output logic [OUTPUT_BITS-1:0] LIGHT_OUT,
   output logic                   VALID,
   output logic                   TIMEOUT,
   output logic                   BUSY,
   output logic                   OVERRUN
);

   localparam int MAX_HALF = calc_max_half(CLOCK_FREQ, LOW_FREQ);
   localparam int MIN_HALF = calc_min_half(CLOCK_FREQ, HIGH_FREQ);
   localparam int STEP     = calc_step(MAX_HALF, MIN_HALF, OUTPUT_BITS);
   localparam int CNT_W    = calc_cnt_w(MAX_HALF);

   localparam logic [CNT_W-1:0] MAX_HALF_C = CNT_W'(MAX_HALF);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(2 * MAX_HALF);
   localparam logic [CNT_W-1:0] HALF_STEP  = CNT_W'(STEP / 2);
   localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] CODE_MAX   = CNT_W'((1 << OUTPUT_BITS) - 1);

   state_t           state;
   logic             sync_a, sync_b, sync_prev, edge_pulse;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] dividend;
   logic [CNT_W-1:0] quotient;
   logic             div_start, div_done;
   logic [OUTPUT_BITS-1:0] light_code;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_a     <= 1'b0;
         sync_b     <= 1'b0;
         sync_prev  <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync_a     <= FREQ_IN;
         sync_b     <= sync_a;
         sync_prev  <= sync_b;
         edge_pulse <= sync_b ^ sync_prev;
      end
   end

   // Restarting at 1 makes the count seen during the next edge cycle equal the half period.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                  cnt <= '0;
      else if (edge_pulse)      cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;
   end

   always_comb begin
      dividend = '0;
      if (cnt < MAX_HALF_C) dividend = MAX_HALF_C - cnt + HALF_STEP;
   end

   assign div_start = ENABLE && (state == ST_MEASURE) && edge_pulse;

   freq_seq_divider #(.WIDTH(CNT_W)) u_divider (
      .clk      (CLK),
      .rst      (RST),
      .start    (div_start),
      .abort    (!ENABLE),
      .dividend (dividend),
      .divisor  (STEP_C),
      .quotient (quotient),
      .done     (div_done)
   );

   assign light_code = (quotient > CODE_MAX) ? OUTPUT_BITS'(CODE_MAX) : OUTPUT_BITS'(quotient);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_ARM;
         LIGHT_OUT <= '0;
         VALID     <= 1'b0;
         TIMEOUT   <= 1'b0;
         BUSY      <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         VALID   <= 1'b0;
         TIMEOUT <= 1'b0;
         OVERRUN <= 1'b0;
         if (!ENABLE) begin
            state <= ST_ARM;
            BUSY  <= 1'b0;
         end else begin
            case (state)
               ST_ARM: begin
                  if (edge_pulse) state <= ST_MEASURE;
               end
               ST_MEASURE: begin
                  if (edge_pulse) begin
                     state <= ST_DIVIDE;
                     BUSY  <= 1'b1;
                  end else if (cnt == CNT_MAX) begin
                     VALID     <= 1'b1;
                     TIMEOUT   <= 1'b1;
                     LIGHT_OUT <= '0;
                     state     <= ST_ARM;
                  end
               end
               ST_DIVIDE: begin
                  // An interval closing while the divider is busy has nowhere to go.
                  if (edge_pulse) OVERRUN <= 1'b1;
                  if (div_done) begin
                     VALID     <= 1'b1;
                     LIGHT_OUT <= light_code;
                     BUSY      <= 1'b0;
                     state     <= ST_MEASURE;
                  end
               end
               default: state <= ST_ARM;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frequency_readout.sv
// Directed bench for frequency_readout at default parameters
// (MAX_HALF=25000, STEP=98, CNT_W=16).
module tb_frequency_readout;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       freq_in;
   logic [7:0] light_out;
   logic       valid;
   logic       timeout;
   logic       busy;
   logic       overrun;

   frequency_readout dut (
      .CLK       (clk),
      .RST       (rst),
      .ENABLE    (enable),
      .FREQ_IN   (freq_in),
      .LIGHT_OUT (light_out),
      .VALID     (valid),
      .TIMEOUT   (timeout),
      .BUSY      (busy),
      .OVERRUN   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;
   int cyc;
   int last_toggle;
   int valid_n;
   int last_valid_cyc;
   int last_light;
   int last_to;
   int to_n;
   int ovr_n;
   int min_gap;
   int min_light;
   int max_light;
   int vbase;

   task automatic check(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // One cycle: wait for the falling edge, then record what the DUT shows.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (valid) begin
         valid_n++;
         if (valid_n > 1 && (cyc - last_valid_cyc) < min_gap) min_gap = cyc - last_valid_cyc;
         last_valid_cyc = cyc;
         last_light     = int'(light_out);
         last_to        = int'(timeout);
         if (timeout) to_n++;
         if (last_light < min_light) min_light = last_light;
         if (last_light > max_light) max_light = last_light;
      end
      if (overrun) ovr_n++;
   endtask

   task automatic settle(input int n);
      repeat (n) step();
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic toggle();
      freq_in     = ~freq_in;
      last_toggle = cyc;
   endtask

   // Toggle FREQ_IN h cycles after the previous toggle: one interval of H = h.
   task automatic half(input int h);
      wait_until(last_toggle + h);
      toggle();
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0; last_toggle = 0;
      valid_n = 0; last_valid_cyc = 0; last_light = 0; last_to = 0;
      to_n = 0; ovr_n = 0; min_gap = 1 << 30; min_light = 1 << 30; max_light = -1;
      rst = 1'b1; enable = 1'b0; freq_in = 1'b0;
      settle(3);
      check("rst_light",   int'(light_out), 0);
      check("rst_valid",   int'(valid),     0);
      check("rst_timeout", int'(timeout),   0);
      check("rst_busy",    int'(busy),      0);
      check("rst_overrun", int'(overrun),   0);

      // H=25000: ARM edge first (unreported), then one full interval -> code 0.
      rst = 1'b0; enable = 1'b1;
      settle(5);
      vbase = valid_n;
      toggle();
      wait_until(last_toggle + 25000);
      check("arm_unreported", valid_n - vbase, 0);
      toggle();
      settle(25);
      check("h25000_count",   valid_n - vbase, 1);
      check("h25000_light",   last_light, 0);
      check("h25000_timeout", last_to, 0);
      check("h25000_latency", last_valid_cyc - last_toggle, 20);

      // (25000-12456+49)/98 = 128.5 -> 128
      half(12456);
      settle(25);
      check("h12456_count",   valid_n - vbase, 2);
      check("h12456_light",   last_light, 128);
      check("h12456_timeout", last_to, 0);

      // Drop ENABLE mid-divide: no VALID, LIGHT_OUT held, BUSY cleared.
      half(200);
      settle(10);
      check("abort_busy_before", int'(busy), 1);
      enable = 1'b0;
      wait_until(last_toggle + 40);
      check("abort_no_valid",   valid_n - vbase, 2);
      check("abort_light_held", int'(light_out), 128);
      check("abort_busy_after", int'(busy), 0);

      // Re-arm, then H=1: (25000-1+49)/98 = 255.6 -> 255
      enable = 1'b1;
      settle(5);
      toggle();
      half(1);
      settle(25);
      check("h1_count",   valid_n - vbase, 3);
      check("h1_light",   last_light, 255);
      check("h1_latency", last_valid_cyc - last_toggle, 20);

      // Hold FREQ_IN: counter hits 50000 after the edge pulse (toggle+3), VALID one cycle later.
      to_n = 0;
      wait_until(last_toggle + 50004 + 100);
      check("to_count",       to_n, 1);
      check("to_total_valid", valid_n - vbase, 4);
      check("to_flag",        last_to, 1);
      check("to_light",       last_light, 0);
      check("to_latency",     last_valid_cyc - last_toggle, 50004);

      // H=3 square wave: intervals closing mid-divide are dropped.
      to_n = 0; ovr_n = 0; min_gap = 1 << 30; min_light = 1 << 30; max_light = -1;
      vbase = valid_n;
      repeat (40) half(3);
      settle(25);
      check("h3_overrun_seen", int'(ovr_n > 0), 1);
      check("h3_valid_ge4",    int'((valid_n - vbase) >= 4), 1);
      check("h3_min_light",    min_light, 255);
      check("h3_max_light",    max_light, 255);
      check("h3_gap_ge17",     int'(min_gap >= 17), 1);
      check("h3_no_timeout",   to_n, 0);

      // Reset in the middle of a divide.
      settle(30);
      toggle();
      settle(8);
      check("rstmid_busy_before", int'(busy), 1);
      rst = 1'b1; freq_in = 1'b0;
      #1;
      check("rstmid_light",   int'(light_out), 0);
      check("rstmid_valid",   int'(valid),     0);
      check("rstmid_timeout", int'(timeout),   0);
      check("rstmid_busy",    int'(busy),      0);
      check("rstmid_overrun", int'(overrun),   0);
      vbase = valid_n;
      settle(3);
      rst = 1'b0;
      settle(60);
      check("rstmid_quiet", valid_n - vbase, 0);
      toggle();
      wait_until(last_toggle + 2000);
      check("rstmid_one_edge", valid_n - vbase, 0);
      toggle();
      settle(19);
      check("rstmid_not_early", valid_n - vbase, 0);
      settle(6);
      // (25000-2000+49)/98 = 235.2 -> 235
      check("rstmid_count",   valid_n - vbase, 1);
      check("rstmid_light2",  last_light, 235);
      check("rstmid_latency", last_valid_cyc - last_toggle, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
